// File: rtl/redstone_pkg.sv
// Shared definitions for redstone-style timing blocks.
//   DEFAULT_MAX_DELAY : default largest repeater delay in ticks
//   dw_of()           : width of a delay code field for a given MAX_DELAY
package redstone_pkg;

  localparam int DEFAULT_MAX_DELAY = 4;

  // Delay codes hold delay-1, so MAX_DELAY values need clog2(MAX_DELAY) bits,
  // but a field is never narrower than one bit.
  function automatic int dw_of(input int max_delay);
    if (max_delay <= 32'sd2) begin
      return 32'sd1;
    end else begin
      return $clog2(max_delay);
    end
  endfunction

endpackage

// File: rtl/repeater_channel.sv
// One redstone repeater channel: delays each input change by D ticks and
// stretches short pulses to D ticks; can be frozen by a lock input.
// Ports:
//   i_clk   : clock, one rising edge per tick
//   i_rst   : synchronous active-high reset
//   i_in    : repeater input
//   i_lock  : lock request (ignored when LOCKABLE = 0)
//   i_delay : delay code, effective delay = min(code+1, MAX_DELAY)
//   o_out   : registered repeater output
//   o_busy  : high while a change is scheduled
module repeater_channel
  import redstone_pkg::*;
#(
  parameter int   MAX_DELAY = DEFAULT_MAX_DELAY,
  parameter logic INIT      = 1'b0,
  parameter logic LOCKABLE  = 1'b1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_in,
  input  logic                         i_lock,
  input  logic [dw_of(MAX_DELAY)-1:0]  i_delay,
  output logic                         o_out,
  output logic                         o_busy
);

  localparam int          DW    = dw_of(MAX_DELAY);
  localparam logic [DW:0] MAX_D = (DW+1)'(MAX_DELAY);
  localparam logic [DW:0] ONE   = (DW+1)'(32'sd1);
  localparam logic [DW:0] TWO   = (DW+1)'(32'sd2);

  logic          out_r;
  logic          pending_r;
  logic          target_r;
  logic [DW-1:0] count_r;

  logic          out_s;
  logic          pending_s;
  logic          target_s;
  logic [DW-1:0] count_s;
  logic [DW:0]   code_plus1_s;
  logic [DW:0]   eff_delay_s;
  logic          lock_s;

  // Next-state logic; priority is lock > pending countdown > new schedule.
  always_comb begin
    out_s        = out_r;
    pending_s    = pending_r;
    target_s     = target_r;
    count_s      = count_r;
    code_plus1_s = {1'b0, i_delay} + ONE;
    eff_delay_s  = (code_plus1_s > MAX_D) ? MAX_D : code_plus1_s;
    lock_s       = i_lock & LOCKABLE;

    if (lock_s) begin
      pending_s = 1'b0;
      count_s   = {DW{1'b0}};
    end else if (pending_r) begin
      // Input and delay code are ignored while a change is in flight, which
      // is what stretches short pulses out to the full delay.
      if (count_r != {DW{1'b0}}) begin
        count_s = count_r - {{(DW-1){1'b0}}, 1'b1};
      end else begin
        out_s     = target_r;
        pending_s = 1'b0;
      end
    end else if (i_in != out_r) begin
      if (eff_delay_s == ONE) begin
        out_s = i_in;
      end else begin
        // Schedule edge counts as one tick, output update edge as another.
        pending_s = 1'b1;
        target_s  = i_in;
        count_s   = DW'(eff_delay_s - TWO);
      end
    end else begin
      pending_s = pending_r;
    end
  end

  // Channel state register with synchronous reset to the INIT value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_r     <= INIT;
      pending_r <= 1'b0;
      target_r  <= INIT;
      count_r   <= {DW{1'b0}};
    end else begin
      out_r     <= out_s;
      pending_r <= pending_s;
      target_r  <= target_s;
      count_r   <= count_s;
    end
  end

  assign o_out  = out_r;
  assign o_busy = pending_r;

endmodule

// File: rtl/repeater_bank.sv
// Bank of independent redstone repeater channels.
// Ports:
//   i_clk   : clock, one rising edge per tick
//   i_rst   : synchronous active-high reset
//   i_in    : per-channel inputs
//   i_lock  : per-channel locks
//   i_delay : per-channel delay codes, channel ch at [ch*DW +: DW]
//   o_out   : per-channel registered outputs
//   o_busy  : per-channel "change scheduled" flags
module repeater_bank
  import redstone_pkg::*;
#(
  parameter int                  CHANNELS  = 8,
  parameter int                  MAX_DELAY = DEFAULT_MAX_DELAY,
  parameter logic [CHANNELS-1:0] INIT      = {CHANNELS{1'b0}},
  parameter logic [CHANNELS-1:0] LOCKABLE  = {CHANNELS{1'b1}}
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [CHANNELS-1:0]                   i_in,
  input  logic [CHANNELS-1:0]                   i_lock,
  input  logic [CHANNELS*dw_of(MAX_DELAY)-1:0]  i_delay,
  output logic [CHANNELS-1:0]                   o_out,
  output logic [CHANNELS-1:0]                   o_busy
);

  localparam int DW = dw_of(MAX_DELAY);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    repeater_channel #(
      .MAX_DELAY (MAX_DELAY),
      .INIT      (INIT[ch]),
      .LOCKABLE  (LOCKABLE[ch])
    ) u_channel (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_in    (i_in[ch]),
      .i_lock  (i_lock[ch]),
      .i_delay (i_delay[ch*DW +: DW]),
      .o_out   (o_out[ch]),
      .o_busy  (o_busy[ch])
    );
  end

endmodule

// File: tb/tb_repeater_bank.sv
// Scoreboard bench for repeater_bank. Bank A uses default INIT/LOCKABLE,
// bank B uses INIT=8'hA5 and LOCKABLE=8'hDF. Expected output/busy values are
// pushed, tagged with the edge they apply to, when stimulus is driven and
// compared #1 after that edge.
module tb_repeater_bank;

  localparam int A_OUT  = 0;
  localparam int A_BUSY = 1;
  localparam int B_OUT  = 2;
  localparam int B_BUSY = 3;

  logic        clk = 1'b0;
  logic        a_rst, b_rst;
  logic [7:0]  a_in, a_lock, a_out, a_busy;
  logic [7:0]  b_in, b_lock, b_out, b_busy;
  logic [15:0] a_delay, b_delay;

  typedef struct {
    int         edge_n;
    int         sel;
    int         ch;
    logic [7:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  repeater_bank #(
    .CHANNELS (8), .MAX_DELAY (4), .INIT (8'h00), .LOCKABLE (8'hFF)
  ) dut_a (
    .i_clk (clk), .i_rst (a_rst), .i_in (a_in), .i_lock (a_lock),
    .i_delay (a_delay), .o_out (a_out), .o_busy (a_busy)
  );

  repeater_bank #(
    .CHANNELS (8), .MAX_DELAY (4), .INIT (8'hA5), .LOCKABLE (8'hDF)
  ) dut_b (
    .i_clk (clk), .i_rst (b_rst), .i_in (b_in), .i_lock (b_lock),
    .i_delay (b_delay), .o_out (b_out), .o_busy (b_busy)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic void push(input int e, input int sel, input int ch,
                               input logic [7:0] exp, input string tag);
    exp_t x;
    x.edge_n = e;
    x.sel    = sel;
    x.ch     = ch;
    x.exp    = exp;
    x.tag    = tag;
    sb.push_back(x);
  endfunction

  // Drive inputs for edge k and queue the expectations that follow from them.
  task automatic drive(input int k);
    a_rst   = (k < 2);
    b_rst   = (k < 2) || (k == 41);
    a_in    = 8'h00;
    a_in[0] = (k >= 10);
    a_in[1] = (k == 20);
    a_in[2] = (k >= 15 && k <= 24) ? (k % 2 == 1) : 1'b0;
    a_in[3] = (k >= 6);
    a_in[4] = (k >= 30 && k < 35);
    a_lock    = 8'h00;
    a_lock[3] = (k >= 5 && k <= 11);
    // codes: ch0=3 ch1=3 ch2=0 ch3=1 ch4=3 (0 from edge 31)
    a_delay = {2'd0, 2'd0, 2'd0, ((k >= 31) ? 2'd0 : 2'd3), 2'd1, 2'd0, 2'd3, 2'd3};
    b_in    = 8'hA5;
    b_in[0] = !(k >= 38 && k < 41);
    b_in[5] = (k < 46);
    b_in[7] = (k < 46);
    b_lock  = (k >= 45 && k <= 55) ? 8'hFF : 8'h00;
    b_delay = {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3};

    if (k == 0) begin
      push(0, A_OUT, -1, 8'h00, "rst_a_out");
      push(0, A_BUSY, -1, 8'h00, "rst_a_busy");
      push(0, B_OUT, -1, 8'hA5, "rst_b_out");
      push(0, B_BUSY, -1, 8'h00, "rst_b_busy");
    end
    if (k == 9) push(9, A_OUT, 0, 8'h00, "d4_pre");
    if (k == 10) begin
      for (int e = 10; e <= 12; e++) push(e, A_BUSY, 0, 8'h01, "d4_busy");
      push(12, A_OUT, 0, 8'h00, "d4_early");
      push(13, A_OUT, 0, 8'h01, "d4_rise");
      push(13, A_BUSY, 0, 8'h00, "d4_done");
      push(14, A_OUT, 0, 8'h01, "d4_hold");
    end
    if (k == 20) begin
      push(20, A_BUSY, 1, 8'h01, "pulse_busy");
      push(22, A_OUT, 1, 8'h00, "pulse_early");
      for (int e = 23; e <= 26; e++) push(e, A_OUT, 1, 8'h01, "pulse_high");
      push(24, A_BUSY, 1, 8'h01, "pulse_fall_busy");
      push(27, A_OUT, 1, 8'h00, "pulse_low");
      push(27, A_BUSY, 1, 8'h00, "pulse_idle");
    end
    if (k >= 15 && k <= 25) begin
      push(k, A_OUT, 2, {7'd0, a_in[2]}, "d1_follow");
      push(k, A_BUSY, 2, 8'h00, "d1_busy");
    end
    if (k == 6) begin
      for (int e = 6; e <= 12; e++) push(e, A_OUT, 3, 8'h00, "lock_hold");
      push(11, A_BUSY, 3, 8'h00, "lock_nobusy");
      push(12, A_BUSY, 3, 8'h01, "unlock_sched");
      push(13, A_OUT, 3, 8'h01, "unlock_rise");
    end
    if (k == 30) begin
      for (int e = 30; e <= 32; e++) push(e, A_OUT, 4, 8'h00, "midcode_early");
      for (int e = 30; e <= 32; e++) push(e, A_BUSY, 4, 8'h01, "midcode_busy");
      push(33, A_OUT, 4, 8'h01, "midcode_rise");
      push(34, A_OUT, 4, 8'h01, "midcode_hold");
    end
    if (k == 35) begin
      push(35, A_OUT, 4, 8'h00, "newcode_d1");
      push(35, A_BUSY, 4, 8'h00, "newcode_busy");
    end
    if (k == 38) begin
      for (int e = 38; e <= 40; e++) push(e, B_BUSY, 0, 8'h01, "b_pend_busy");
      push(40, B_OUT, 0, 8'h01, "b_pend_out");
    end
    if (k == 41) begin
      push(41, B_OUT, -1, 8'hA5, "midrst_out");
      push(41, B_BUSY, -1, 8'h00, "midrst_busy");
      for (int e = 42; e <= 45; e++) push(e, B_OUT, 0, 8'h01, "midrst_discard");
      for (int e = 42; e <= 45; e++) push(e, B_BUSY, 0, 8'h00, "midrst_idle");
      push(42, B_OUT, -1, 8'hA5, "resume_out");
    end
    if (k == 46) begin
      push(46, B_OUT, 5, 8'h00, "unlockable_ch5");
      for (int e = 46; e <= 55; e++) push(e, B_OUT, 7, 8'h01, "locked_ch7");
      push(56, B_OUT, 7, 8'h00, "unlocked_ch7");
    end
  endtask

  // Compare every queued expectation that belongs to edge k, then drop it.
  task automatic score(input int k);
    int         i;
    logic [7:0] vec;
    logic [7:0] got;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].edge_n == k) begin
        case (sb[i].sel)
          A_OUT:   vec = a_out;
          A_BUSY:  vec = a_busy;
          B_OUT:   vec = b_out;
          default: vec = b_busy;
        endcase
        got = (sb[i].ch < 0) ? vec : {7'd0, vec[sb[i].ch]};
        check_eq($sformatf("%s@%0d", sb[i].tag, k), got, sb[i].exp);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  initial begin
    for (int k = 0; k <= 57; k++) begin
      drive(k);
      @(posedge clk);
      #1;
      score(k);
    end
    check_eq("sb_drained", 8'(sb.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
